// File: rtl/rr_mux_arb_if.sv
// Handshake bundle for rr_mux_arb: N request channels in, one registered output beat.
// in_last is present only when RR_MUX_ARB_LOCK_EN is defined.
interface rr_mux_arb_if #(
   parameter int W  = 4,
   parameter int N  = 4,
   parameter int SW = $clog2(N)
);
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
`ifdef RR_MUX_ARB_LOCK_EN
   logic [N-1:0]   in_last;
`endif
   logic           force_en;
   logic [SW-1:0]  force_sel;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_sel;
   logic           out_ready;

`ifdef RR_MUX_ARB_LOCK_EN
   modport master (
      output in_valid, in_data, in_last, force_en, force_sel, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
   modport slave (
      input  in_valid, in_data, in_last, force_en, force_sel, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
`else
   modport master (
      output in_valid, in_data, force_en, force_sel, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
   modport slave (
      input  in_valid, in_data, force_en, force_sel, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
`endif
endinterface

// File: rtl/rr_mux_arb.sv
// N-to-1 round-robin (or forced-select) mux with a single registered output stage.
// Optional packet lock on in_last is enabled by defining RR_MUX_ARB_LOCK_EN.
module rr_mux_arb #(
   parameter int W  = 4,
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic        clk,
   input  logic        rst_n,
   rr_mux_arb_if.slave bus
);
   logic [SW-1:0] ptr;
   logic          ld;
   logic          xfer;
   logic          gnt_vld;
   logic [SW-1:0] gnt_idx;
   logic          adv_ptr;
   logic          beat_last;
   logic [SW-1:0] ptr_inc;
   logic          rr_vld;
   logic [SW-1:0] rr_idx;
   logic [SW-1:0] rr_cidx;
   int unsigned   rr_c;
   logic          f_ok;

`ifdef RR_MUX_ARB_LOCK_EN
   typedef enum logic {ST_OPEN, ST_LOCKED} lock_st_t;
   lock_st_t      lock_st, lock_nxt;
   logic [SW-1:0] lock_ch, lock_ch_nxt;
`endif

   assign ld   = !bus.out_valid || bus.out_ready;
   assign xfer = gnt_vld && ld;

   // First requester at or after ptr, wrapping modulo N.
   always_comb begin
      rr_vld  = 1'b0;
      rr_idx  = '0;
      rr_c    = 0;
      rr_cidx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         rr_c    = (32'(ptr) + k) % N;
         rr_cidx = SW'(rr_c);
         if (!rr_vld && bus.in_valid[rr_cidx]) begin
            rr_vld = 1'b1;
            rr_idx = rr_cidx;
         end
      end
   end

   assign f_ok = (32'(bus.force_sel) < N) && bus.in_valid[bus.force_sel];

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      adv_ptr = 1'b0;
      if (bus.force_en) begin
         gnt_vld = f_ok;
         gnt_idx = bus.force_sel;
      end else begin
         gnt_vld = rr_vld;
         gnt_idx = rr_idx;
         adv_ptr = 1'b1;
      end
`ifdef RR_MUX_ARB_LOCK_EN
      // An open packet overrides both arbitration and the force controls.
      if (lock_st == ST_LOCKED) begin
         gnt_vld = bus.in_valid[lock_ch];
         gnt_idx = lock_ch;
         adv_ptr = 1'b1;
      end
`endif
   end

   always_comb begin
      bus.in_ready = '0;
      if (xfer && rst_n)
         bus.in_ready[gnt_idx] = 1'b1;
   end

   assign ptr_inc = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + SW'(1);

`ifdef RR_MUX_ARB_LOCK_EN
   assign beat_last = bus.in_last[gnt_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_st <= ST_OPEN;
         lock_ch <= '0;
      end else begin
         lock_st <= lock_nxt;
         lock_ch <= lock_ch_nxt;
      end
   end

   always_comb begin
      lock_nxt    = lock_st;
      lock_ch_nxt = lock_ch;
      if (xfer) begin
         lock_nxt    = beat_last ? ST_OPEN : ST_LOCKED;
         lock_ch_nxt = gnt_idx;
      end
   end
`else
   assign beat_last = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sel   <= '0;
         ptr           <= '0;
      end else begin
         if (ld) begin
            bus.out_valid <= gnt_vld;
            if (gnt_vld) begin
               bus.out_data <= bus.in_data[int'(gnt_idx) * W +: W];
               bus.out_sel  <= gnt_idx;
            end
         end
         if (xfer && adv_ptr && beat_last)
            ptr <= ptr_inc;
      end
   end
endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter W, default 4: data width per channel, 1..64.
REQ-002 Parameter N, default 4: channel count, 2..16.
REQ-003 Parameter SW, default $clog2(N): select/index width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  N  per-channel request; bit i belongs to channel i.
REQ-007 in_data  input  N*W  channel i data in bits [i*W +: W].
REQ-008 in_ready  output  N  per-channel accept; one-hot or zero.
REQ-009 force_en  input  1  1 = fixed select, 0 = round-robin arbitration.
REQ-010 force_sel  input  SW  channel index used when force_en=1.
REQ-011 out_valid  output  1  output register holds a beat.
REQ-012 out_data  output  W  registered selected data.
REQ-013 out_sel  output  SW  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 Transfer on channel i when in_valid[i] && in_ready[i] at a rising clk; output transfer when out_valid && out_ready.
REQ-016 Load enable: ld = !out_valid || out_ready; in_ready is all-zero when ld=0.
REQ-017 Round-robin mode: grant goes to the first requesting channel searching ptr, ptr+1, ... N-1, 0, ... (mod N); in_ready[grant]=ld.
REQ-018 ptr is SW bits and resets to 0; after an input transfer from channel g, ptr <= (g+1) mod N, with N-1 wrapping to 0.
REQ-019 Forced mode: grant = force_sel when in_valid[force_sel]=1, otherwise no grant; ptr is unchanged.
REQ-020 force_sel >= N: no grant, all in_ready=0, no error flag.
REQ-021 Latency one cycle: a beat accepted at edge k appears on out_data/out_sel with out_valid=1 after edge k.
REQ-022 Simultaneous output drain and input accept at the same edge: the register reloads; out_valid stays 1 and no bubble is inserted.
REQ-023 ld=1 with no grant: out_valid <= 0; out_data and out_sel hold their previous values.
REQ-024 While out_valid=1 && out_ready=0, out_data, out_sel and out_valid remain stable.
REQ-025 in_ready and the grant are combinational from in_valid, ptr, force_en, force_sel and out_ready; there is no path from in_data.
REQ-026 A force_en change takes effect in the same cycle; a beat already held in the output register is unaffected.
REQ-027 Sustained throughput: one beat per cycle while out_ready=1 and at least one valid is granted.

Reset
REQ-028 When rst_n=0, asynchronously force out_valid=0, out_data=0, out_sel=0, ptr=0 and lock state cleared.
REQ-029 Reset mid-transfer discards the held beat without emitting it; the first post-reset grant searches from channel 0.
REQ-030 in_ready is all-zero while rst_n=0.

Configuration
REQ-031 Macro RR_MUX_ARB_LOCK_EN defined: add input in_last (N bits); after channel g transfers a beat with in_last[g]=0, grant stays locked to g (other channels get in_ready=0) until g transfers a beat with in_last[g]=1; only then does ptr advance.
REQ-032 While locked, force_en/force_sel are ignored until the in_last=1 beat transfers.
REQ-033 Macro RR_MUX_ARB_LOCK_EN undefined: no in_last port, no lock state; every beat re-arbitrates per REQ-017..019.

Verification
REQ-034 Round-robin: N=4, W=4, all in_valid=1 with in_data i=4'hA+i, out_ready=1 -> out_sel 0,1,2,3,0; out_data A,B,C,D,A, one per cycle.
REQ-035 Backpressure: out_ready=0 for 3 cycles with a beat held -> out_data/out_sel stable, in_ready=0; release -> that beat drains and the next beat loads at the same edge.
REQ-036 Forced mode: force_en=1, force_sel=2, in_valid=4'b1111 -> only in_ready[2]=1, out_sel=2 every cycle, ptr unchanged; force_sel=2 with in_valid[2]=0 -> out_valid falls to 0.
REQ-037 Wrap and skip: ptr=3, in_valid=4'b0010 -> grant channel 1, ptr becomes 2; next with in_valid=4'b0101 -> grant channel 2.
REQ-038 Reset: rst_n low asynchronously mid-stream while out_valid=1 -> out_valid=0, out_sel=0 before the next edge; after release with all valid -> first out_sel=0.
REQ-039 Lock (RR_MUX_ARB_LOCK_EN): channel 1 sends 3 beats with in_last 0,0,1 while channels 0 and 2 are valid -> out_sel 1,1,1, then 2.
